// File: rtl/debounce_multi_if.sv
// Button bus between the board pins and the debounce conditioner.
// The master drives raw buttons; the slave returns level and strobes.
interface debounce_multi_if #(
   parameter int N_CH = 4
);
   logic [N_CH-1:0] btn_in;
   logic [N_CH-1:0] btn_level;
   logic [N_CH-1:0] btn_press;
   logic [N_CH-1:0] btn_release;

   modport master (
      output btn_in,
      input  btn_level,
      input  btn_press,
      input  btn_release
   );

   modport slave (
      input  btn_in,
      output btn_level,
      output btn_press,
      output btn_release
   );
endinterface

// File: rtl/debounce_multi.sv
// N-channel push-button conditioner: 2-FF synchroniser, stability filter,
// press/release strobes and optional auto-repeat of the press strobe.
module debounce_multi #(
   parameter int N_CH          = 4,
   parameter int STABLE_CYCLES = 1000000,
   parameter int REPEAT_EN     = 1,
   parameter int REPEAT_DELAY  = 50000000,
   parameter int REPEAT_RATE   = 10000000
) (
   input  logic            clk_in,
   input  logic            rst,
   debounce_multi_if.slave bus
);
   localparam int CW   = $clog2(STABLE_CYCLES + 1);
   localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int RW   = $clog2(RMAX + 1);

   localparam logic [CW-1:0] STABLE_M1 = CW'(STABLE_CYCLES - 1);
   localparam logic [RW-1:0] DELAY_M1  = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] RATE_M1   = RW'(REPEAT_RATE - 1);

   typedef enum logic [1:0] {
      ST_RELEASED,
      ST_HELD_DELAY,
      ST_HELD_REPEAT
   } state_t;

   logic [N_CH-1:0] w_level;
   logic [N_CH-1:0] w_press;
   logic [N_CH-1:0] w_release;

   generate
      for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
         logic          r_s1;
         logic          r_sync;
         logic          r_level;
         logic          r_press;
         logic          r_release;
         logic [CW-1:0] r_cnt;
         logic [RW-1:0] r_rcnt;
         logic [RW-1:0] w_rcnt_next;
         state_t        r_state;
         state_t        w_state_next;
         logic          w_accept;
         logic          w_rise;
         logic          w_fall;
         logic          w_press_next;
         logic          w_release_next;

         // A differing synchronised value is accepted on its last stable cycle.
         assign w_accept = (r_sync != r_level) && (r_cnt == STABLE_M1);
         assign w_rise   = w_accept && r_sync;
         assign w_fall   = w_accept && !r_sync;

         always_ff @(posedge clk_in) begin
            if (rst) begin
               r_s1    <= 1'b0;
               r_sync  <= 1'b0;
               r_cnt   <= '0;
               r_level <= 1'b0;
            end else begin
               r_s1   <= bus.btn_in[gi];
               r_sync <= r_s1;
               if (r_sync == r_level) begin
                  r_cnt <= '0;
               end else if (r_cnt == STABLE_M1) begin
                  r_level <= r_sync;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
         end

         always_ff @(posedge clk_in) begin
            if (rst) begin
               r_state   <= ST_RELEASED;
               r_rcnt    <= '0;
               r_press   <= 1'b0;
               r_release <= 1'b0;
            end else begin
               r_state   <= w_state_next;
               r_rcnt    <= w_rcnt_next;
               r_press   <= w_press_next;
               r_release <= w_release_next;
            end
         end

         always_comb begin
            w_state_next   = r_state;
            w_rcnt_next    = r_rcnt;
            w_press_next   = 1'b0;
            w_release_next = 1'b0;
            case (r_state)
               ST_RELEASED: begin
                  if (w_rise) begin
                     w_state_next = ST_HELD_DELAY;
                     w_rcnt_next  = '0;
                     w_press_next = 1'b1;
                  end
               end
               ST_HELD_DELAY: begin
                  if (w_fall) begin
                     w_state_next   = ST_RELEASED;
                     w_rcnt_next    = '0;
                     w_release_next = 1'b1;
                  end else if (r_rcnt == DELAY_M1) begin
                     // Without auto-repeat the counter parks here silently.
                     if (REPEAT_EN != 0) begin
                        w_state_next = ST_HELD_REPEAT;
                        w_rcnt_next  = '0;
                        w_press_next = 1'b1;
                     end
                  end else begin
                     w_rcnt_next = r_rcnt + 1'b1;
                  end
               end
               ST_HELD_REPEAT: begin
                  if (w_fall) begin
                     w_state_next   = ST_RELEASED;
                     w_rcnt_next    = '0;
                     w_release_next = 1'b1;
                  end else if (r_rcnt == RATE_M1) begin
                     w_rcnt_next  = '0;
                     w_press_next = 1'b1;
                  end else begin
                     w_rcnt_next = r_rcnt + 1'b1;
                  end
               end
               default: begin
                  w_state_next = ST_RELEASED;
                  w_rcnt_next  = '0;
               end
            endcase
         end

         assign w_level[gi]   = r_level;
         assign w_press[gi]   = r_press;
         assign w_release[gi] = r_release;
      end
   endgenerate

   assign bus.btn_level   = w_level;
   assign bus.btn_press   = w_press;
   assign bus.btn_release = w_release;
endmodule

// File: tb/tb_debounce_multi.sv
// Directed bench for debounce_multi with STABLE_CYCLES=4, REPEAT_DELAY=10,
// REPEAT_RATE=3; every edge of every scenario is checked against hand values.
module tb_debounce_multi;
   logic clk_in;
   logic rst;
   int   checks;
   int   errors;

   debounce_multi_if #(.N_CH(4)) bus ();

   debounce_multi #(
      .N_CH          (4),
      .STABLE_CYCLES (4),
      .REPEAT_EN     (1),
      .REPEAT_DELAY  (10),
      .REPEAT_RATE   (3)
   ) dut (
      .clk_in (clk_in),
      .rst    (rst),
      .bus    (bus)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk3(input string tag, input logic [3:0] lvl,
                       input logic [3:0] prs, input logic [3:0] rel);
      chk({tag, ".level"},   bus.btn_level,   lvl);
      chk({tag, ".press"},   bus.btn_press,   prs);
      chk({tag, ".release"}, bus.btn_release, rel);
      $display("t=%0t %s in=%b level=%b press=%b release=%b", $time, tag,
               bus.btn_in, bus.btn_level, bus.btn_press, bus.btn_release);
   endtask

   // n edges with a steady level and no strobes
   task automatic idle(input int n, input logic [3:0] lvl, input string tag);
      for (int i = 0; i < n; i++) begin
         step();
         chk3(tag, lvl, 4'b0000, 4'b0000);
      end
   endtask

   initial begin
      logic [5:0] bounce;
      checks = 0;
      errors = 0;

      // Reset held with all buttons down: outputs stay 0, then re-accept on edge 6
      rst        = 1'b1;
      bus.btn_in = 4'b1111;
      idle(3, 4'b0000, "reset_hold");
      rst = 1'b0;
      idle(5, 4'b0000, "post_reset_wait");
      step(); chk3("post_reset_press", 4'b1111, 4'b1111, 4'b0000);
      idle(9, 4'b1111, "all_held");
      step(); chk3("all_repeat1", 4'b1111, 4'b1111, 4'b0000);
      idle(2, 4'b1111, "all_held_r");
      step(); chk3("all_repeat2", 4'b1111, 4'b1111, 4'b0000);
      bus.btn_in = 4'b0000;
      idle(2, 4'b1111, "all_releasing");
      step(); chk3("all_repeat3", 4'b1111, 4'b1111, 4'b0000);
      idle(2, 4'b1111, "all_releasing2");
      // Release lands on a repeat-due edge: release only
      step(); chk3("all_release_on_repeat", 4'b0000, 4'b0000, 4'b1111);
      idle(3, 4'b0000, "all_idle");

      // Clean press on ch0 with two repeats, release also on a repeat-due edge
      bus.btn_in = 4'b0001;
      idle(5, 4'b0000, "ch0_wait");
      step(); chk3("ch0_press", 4'b0001, 4'b0001, 4'b0000);
      idle(9, 4'b0001, "ch0_held");
      step(); chk3("ch0_repeat_p10", 4'b0001, 4'b0001, 4'b0000);
      idle(2, 4'b0001, "ch0_held_r");
      step(); chk3("ch0_repeat_p13", 4'b0001, 4'b0001, 4'b0000);
      bus.btn_in = 4'b0000;
      idle(2, 4'b0001, "ch0_releasing");
      step(); chk3("ch0_repeat_p16", 4'b0001, 4'b0001, 4'b0000);
      idle(2, 4'b0001, "ch0_releasing2");
      step(); chk3("ch0_release", 4'b0000, 4'b0000, 4'b0001);
      idle(2, 4'b0000, "ch0_idle");

      // Bounce on ch1: 1,0,1,1,0,1 then steady 1
      bounce = 6'b101101;
      for (int i = 5; i >= 0; i--) begin
         bus.btn_in = {2'b00, bounce[i], 1'b0};
         step();
         chk3("ch1_bounce", 4'b0000, 4'b0000, 4'b0000);
      end
      bus.btn_in = 4'b0010;
      idle(4, 4'b0000, "ch1_settling");
      step(); chk3("ch1_press", 4'b0010, 4'b0010, 4'b0000);
      step(); chk3("ch1_after_press", 4'b0010, 4'b0000, 4'b0000);
      bus.btn_in = 4'b0000;
      idle(5, 4'b0010, "ch1_releasing");
      step(); chk3("ch1_release", 4'b0000, 4'b0000, 4'b0010);

      // 3-cycle glitch on ch2 is filtered out entirely
      bus.btn_in = 4'b0100;
      idle(3, 4'b0000, "ch2_glitch_hi");
      bus.btn_in = 4'b0000;
      idle(8, 4'b0000, "ch2_glitch_lo");

      // ch3 held, then ch0 pressed and ch3 released on the same cycle
      bus.btn_in = 4'b1000;
      idle(5, 4'b0000, "ch3_wait");
      step(); chk3("ch3_press", 4'b1000, 4'b1000, 4'b0000);
      bus.btn_in = 4'b0001;
      idle(5, 4'b1000, "swap_wait");
      step(); chk3("swap_edge", 4'b0001, 4'b0001, 4'b1000);

      // Reset mid-hold: outputs cleared with no release, then re-press
      idle(3, 4'b0001, "ch0_hold_pre_rst");
      rst = 1'b1;
      step(); chk3("rst_mid_hold", 4'b0000, 4'b0000, 4'b0000);
      step(); chk3("rst_mid_hold2", 4'b0000, 4'b0000, 4'b0000);
      rst = 1'b0;
      idle(5, 4'b0000, "rst_reaccept_wait");
      step(); chk3("rst_reaccept_press", 4'b0001, 4'b0001, 4'b0000);
      bus.btn_in = 4'b0000;
      idle(2, 4'b0001, "final_hold");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/debounce_multi.md
# debounce_multi

Parametrised N-channel push-button conditioner for the game's control path. Each channel synchronises a raw board button, filters contact bounce with a stability counter, and produces a clean level plus one-cycle press and release strobes. An optional per-channel auto-repeat re-issues press strobes while a button is held, so held direction keys move the rectangle continuously. Sits between the board pins and the rectangle movement/control logic, replacing the fixed four-button debounce wrapper.

## Interface
- N_CH, 4: number of independent button channels (>=1)
- STABLE_CYCLES, 1000000: consecutive synchronised cycles a new value must persist before it is accepted (>=1)
- REPEAT_EN, 1: 1 enables auto-repeat, 0 gives press strobes only on the press edge
- REPEAT_DELAY, 50000000: cycles from the press strobe to the first repeat strobe (>=1)
- REPEAT_RATE, 10000000: cycles between subsequent repeat strobes (>=1)
- clk_in  input  1  system clock; the only clock
- rst  input  1  synchronous, active-high reset
- btn_in  input  N_CH  raw asynchronous button inputs, active high
- btn_level  output  N_CH  debounced button level
- btn_press  output  N_CH  one-cycle strobe on an accepted press and on each auto-repeat
- btn_release  output  N_CH  one-cycle strobe on an accepted release

## Operation
- Channels are fully independent; there is no shared state and no inter-channel priority.
- Synchroniser: 2-FF chain per channel, s1 <= btn_in[i], s <= s1.
- Stability counter cnt, width $clog2(STABLE_CYCLES+1):
  - s == btn_level[i]: cnt <= 0.
  - s != btn_level[i] and cnt == STABLE_CYCLES-1: btn_level[i] <= s, cnt <= 0.
  - Otherwise: cnt <= cnt+1.
  - Any bounce back to the current level before acceptance restarts the count from 0.
- Per-channel FSM:
  - RELEASED: btn_level = 0.
  - HELD_DELAY: held, waiting for the first repeat.
  - HELD_REPEAT: periodic repeat.
- FSM transitions:
  - RELEASED -> HELD_DELAY on accepted 0->1. btn_press pulses on that edge; rcnt <= 0.
  - HELD_DELAY: rcnt increments each cycle. At rcnt == REPEAT_DELAY-1 with REPEAT_EN = 1: btn_press pulses, rcnt <= 0, go to HELD_REPEAT.
  - HELD_REPEAT: at rcnt == REPEAT_RATE-1, btn_press pulses and rcnt <= 0.
  - Any HELD state -> RELEASED on accepted 1->0. btn_release pulses and rcnt <= 0. A repeat due on the same edge is suppressed.
  - With REPEAT_EN = 0, the FSM stays in HELD_DELAY and rcnt saturates or holds (no strobes).
- rcnt width: $clog2(max(REPEAT_DELAY, REPEAT_RATE)+1).
- btn_press and btn_release are never high together on one channel; each is high for exactly one cycle per event.

## Timing
- Reset: s1, s, cnt and rcnt = 0; FSM = RELEASED; btn_level, btn_press and btn_release = 0 on the edge after rst is sampled high.
- Reset mid-hold forces RELEASED with no btn_release strobe.
- A button held through reset is re-accepted as a new press after STABLE_CYCLES+2 edges following rst deassertion.
- Acceptance latency: btn_in changes and then stays stable. btn_level and the strobe update on clock edge STABLE_CYCLES+2 counted from the first edge that samples the new value (2 synchroniser edges + STABLE_CYCLES counting edges).
- All outputs are registered; there is no combinational path from btn_in to any output.
- First repeat strobe: REPEAT_DELAY cycles after the press strobe. Subsequent strobes: every REPEAT_RATE cycles.
- STABLE_CYCLES = 1 is legal: new value accepted on edge 3.

## Test plan
Parameters: N_CH=4, STABLE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3, REPEAT_EN=1.
- Reset: hold rst 3 cycles with btn_in = 4'b1111 -> all outputs 0 during rst. After release, btn_level = 1111 and btn_press = 1111 (single cycle) on edge 6.
- Clean press and release on ch0: press held 20 cycles -> press strobe on edge 6, repeats at +10 and +13, btn_level = 1 throughout. Release -> btn_level = 0 and btn_release strobe 6 edges after the release.
- Bounce on ch1: pattern 1,0,1,1,0,1 then steady 1 -> btn_level rises only 6 edges after the final 0->1. Exactly one press strobe.
- Short glitch on ch2: 3-cycle high pulse -> no change on btn_level, btn_press or btn_release.
- Simultaneous: ch0 pressed while ch3 released on the same cycle -> btn_press[0] and btn_release[3] strobe on the same edge; ch1 and ch2 unaffected.
- Release on a repeat-due cycle, then reset mid-hold: no btn_press on the release edge. A separate hold interrupted by rst -> outputs 0 next edge, no btn_release strobe.
